uart_rx_frame_timer: RTL and testbench
======================================

Name: uart_rx_frame_timer

Overview:
Parametrised successor to the UART RX edge/bit counter. Generates per-bit oversampling timing for one RX frame: an edge counter, a bit counter, a 3-point mid-bit sample window, bit and frame strobes. Frame length is configurable at run time for parity and 1 or 2 stop bits. Sits between the RX start-bit detector/FSM (which drives enable) and the data sampler/deserializer.

Parameters:
PRESC_W, 6, width of prescale input and edge counter (max oversampling 2^PRESC_W-1)
DATA_W, 8, data bits per frame (5..9 legal)
BIT_W, $clog2(DATA_W+5), width of bit counter (derived, not overridden)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
prescale  input  PRESC_W  oversampling ratio (clock edges per bit)
par_en  input  1  1 = frame carries a parity bit
stop2  input  1  1 = two stop bits
enable  input  1  frame in progress (from RX FSM); low aborts/idles
restart  input  1  synchronous clear of counters (glitch/false-start recovery)
edge_cnt  output  PRESC_W  current edge index within bit, 0..prescale_q-1
bit_cnt  output  BIT_W  current bit index within frame, 0 = start bit
sample_en  output  1  high on the three mid-bit sample edges
bit_tick  output  1  one-cycle pulse on last edge of each bit
frame_done  output  1  one-cycle pulse on last edge of last stop bit
busy  output  1  state == COUNT

Behaviour:
- Reset (RST low, async): state IDLE; edge_cnt, bit_cnt, prescale_q, cfg regs = 0; all outputs 0.
- Config capture: on IDLE->COUNT, register prescale_q = max(prescale, 4), frame_len_q = 1 + DATA_W + par_en + 1 + stop2. Changes to prescale/par_en/stop2 mid-frame are ignored.
- FSM states: IDLE, COUNT, DONE.
  IDLE: counters held 0; enable=1 -> COUNT next cycle (first COUNT cycle is edge 0 of bit 0).
  COUNT: edge_cnt += 1 each cycle; at edge_cnt == prescale_q-1: edge_cnt -> 0, bit_cnt += 1. If also bit_cnt == frame_len_q-1: frame_done, bit_cnt -> 0, go to DONE. enable=0 -> IDLE next cycle, counters cleared, no frame_done.
  DONE: counters 0; wait for enable=0 -> IDLE (no retrigger while enable stays high).
- restart=1 (any state, priority over counting, below RST): counters -> 0; next state COUNT if enable=1 (config re-captured), else IDLE. No strobes that cycle.
- Strobes are combinational from registered state only:
  bit_tick = COUNT && edge_cnt == prescale_q-1.
  frame_done = bit_tick && bit_cnt == frame_len_q-1.
  sample_en = COUNT && edge_cnt in {mid-1, mid, mid+1}, mid = prescale_q>>1.
- Frame duration: exactly frame_len_q*prescale_q cycles in COUNT.
- Width rules: all comparisons unsigned at counter width; prescale_q never 0, so no wrap-around on prescale_q-1. bit_cnt never exceeds frame_len_q-1.

Decomposition:
- Package uart_rx_timer_pkg: state enum (IDLE, COUNT, DONE), MIN_PRESCALE = 4, function frame_len(par_en, stop2, DATA_W).
- Single module; no sub-module needed. Sample-window decode can optionally be a function in the package.

Test Plan:
- prescale=8, par_en=0, stop2=0, enable held high -> frame_len 10; bit_tick every 8 cycles; frame_done exactly once, 80 cycles after COUNT entry; then DONE with counters 0 until enable drops.
- prescale=16, par_en=1, stop2=1 -> 12 bits, frame_done at cycle 192; sample_en high at edge_cnt 7,8,9 of every bit.
- prescale=2 -> clamped to 4; sample_en at edge_cnt 1,2,3; bit_tick every 4 cycles.
- prescale changed 8->16 at bit 3 -> current frame keeps 8 (80 cycles); after enable toggles low/high, next frame uses 16.
- enable dropped at bit_cnt=5, edge_cnt=3 -> next cycle IDLE, edge_cnt=bit_cnt=0, busy=0, no frame_done; restart at bit 4 with enable=1 -> counters 0, frame restarts full 80 cycles.
- RST asserted mid-frame (bit 6) -> outputs 0 immediately (async); after release with enable=1, new frame starts from bit 0.

Source files
------------

// File: rtl/uart_rx_frame_timer_pkg.sv
// Shared types and helpers for the UART RX frame timer: FSM encoding,
// prescale floor, and the frame-length rule.
package uart_rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int MIN_PRESCALE = 4;

  // start + data + optional parity + stop + optional second stop
  function automatic int unsigned frame_len(input logic par_en, input logic stop2,
                                            input int unsigned data_w);
    return 32'd2 + data_w + {31'd0, par_en} + {31'd0, stop2};
  endfunction

endpackage

// File: rtl/uart_rx_frame_timer_if.sv
// Control/status bundle between the RX FSM (master) and the frame timer (slave).
interface uart_rx_frame_timer_if #(
  parameter int PRESC_W = 6,
  parameter int DATA_W  = 8
);
  localparam int BIT_W = $clog2(DATA_W + 5);

  logic [PRESC_W-1:0] prescale;
  logic               par_en;
  logic               stop2;
  logic               enable;
  logic               restart;
  logic [PRESC_W-1:0] edge_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               sample_en;
  logic               bit_tick;
  logic               frame_done;
  logic               busy;

  modport master (
    output prescale, par_en, stop2, enable, restart,
    input  edge_cnt, bit_cnt, sample_en, bit_tick, frame_done, busy
  );

  modport slave (
    input  prescale, par_en, stop2, enable, restart,
    output edge_cnt, bit_cnt, sample_en, bit_tick, frame_done, busy
  );

endinterface

// File: rtl/uart_rx_frame_timer.sv
// Per-bit oversampling timer for one UART RX frame: edge/bit counters,
// 3-point mid-bit sample window, bit and frame strobes.
module uart_rx_frame_timer
  import uart_rx_timer_pkg::*;
#(
  parameter int PRESC_W = 6,
  parameter int DATA_W  = 8
) (
  input logic             CLK,
  input logic             RST,
  uart_rx_frame_timer_if.slave tif
);
  localparam int BIT_W = $clog2(DATA_W + 5);

  state_e             state, state_n;
  logic [PRESC_W-1:0] edge_cnt, edge_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [PRESC_W-1:0] prescale_q;
  logic [BIT_W-1:0]   frame_len_q;
  logic               capture;

  logic               counting, last_edge, last_bit, in_window;
  logic [PRESC_W-1:0] mid, presc_clamped;

  assign counting  = (state == COUNT);
  assign last_edge = (edge_cnt == prescale_q - PRESC_W'(1));
  assign last_bit  = (bit_cnt == frame_len_q - BIT_W'(1));
  assign mid       = prescale_q >> 1;
  // prescale_q >= 4 keeps mid-1 positive and mid+1 inside PRESC_W bits
  assign in_window = (edge_cnt >= mid - PRESC_W'(1)) && (edge_cnt <= mid + PRESC_W'(1));

  assign presc_clamped = (tif.prescale < PRESC_W'(MIN_PRESCALE)) ?
                         PRESC_W'(MIN_PRESCALE) : tif.prescale;

  // restart cycle is quiet: no strobes while counters are being cleared
  assign tif.bit_tick   = counting & last_edge & ~tif.restart;
  assign tif.frame_done = counting & last_edge & last_bit & ~tif.restart;
  assign tif.sample_en  = counting & in_window & ~tif.restart;
  assign tif.busy       = counting;
  assign tif.edge_cnt   = edge_cnt;
  assign tif.bit_cnt    = bit_cnt;

  always_comb begin
    state_n = state;
    edge_n  = edge_cnt;
    bit_n   = bit_cnt;
    capture = 1'b0;
    if (tif.restart) begin
      edge_n  = '0;
      bit_n   = '0;
      state_n = tif.enable ? COUNT : IDLE;
      capture = tif.enable;
    end else begin
      case (state)
        IDLE: begin
          edge_n = '0;
          bit_n  = '0;
          if (tif.enable) begin
            state_n = COUNT;
            capture = 1'b1;
          end
        end
        COUNT: begin
          if (!tif.enable) begin
            state_n = IDLE;
            edge_n  = '0;
            bit_n   = '0;
          end else if (last_edge) begin
            edge_n = '0;
            if (last_bit) begin
              bit_n   = '0;
              state_n = DONE;
            end else begin
              bit_n = bit_cnt + BIT_W'(1);
            end
          end else begin
            edge_n = edge_cnt + PRESC_W'(1);
          end
        end
        DONE: begin
          edge_n = '0;
          bit_n  = '0;
          if (!tif.enable) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          edge_n  = '0;
          bit_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      prescale_q  <= '0;
      frame_len_q <= '0;
    end else begin
      state    <= state_n;
      edge_cnt <= edge_n;
      bit_cnt  <= bit_n;
      if (capture) begin
        prescale_q  <= presc_clamped;
        frame_len_q <= BIT_W'(frame_len(tif.par_en, tif.stop2, DATA_W));
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Directed bench for uart_rx_frame_timer; frame lengths are queued at frame
// start and popped when frame_done fires, per-cycle outputs checked against a model.
module tb_uart_rx_frame_timer;
  localparam int PRESC_W = 6;
  localparam int DATA_W  = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];

  uart_rx_frame_timer_if #(.PRESC_W(PRESC_W), .DATA_W(DATA_W)) tif();

  uart_rx_frame_timer #(.PRESC_W(PRESC_W), .DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .tif (tif)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Enable must already be high (or restart pending); the first step lands on edge 0 of bit 0.
  task automatic run_frame(input string tag, input int p, input int fl, input int chg_cyc);
    int cyc, mism, ticks, e, b;
    logic exp_s;
    bit done;
    string first;
    cyc = 0; mism = 0; ticks = 0; done = 0; first = "none";
    exp_q.push_back(p * fl);
    while (!done && cyc < p * fl + 20) begin
      step();
      tif.restart = 1'b0;
      cyc++;
      if (cyc == chg_cyc) begin
        tif.prescale = 16;
        tif.par_en   = 1'b1;
      end
      e = (cyc - 1) % p;
      b = (cyc - 1) / p;
      exp_s = (e >= (p >> 1) - 1) && (e <= (p >> 1) + 1);
      if (cyc <= p * fl) begin
        if (tif.busy !== 1'b1 || int'(tif.edge_cnt) != e || int'(tif.bit_cnt) != b ||
            tif.sample_en !== exp_s || tif.bit_tick !== (e == p - 1) ||
            tif.frame_done !== (cyc == p * fl)) begin
          if (mism == 0) first = $sformatf("cyc%0d", cyc);
          mism++;
        end
      end
      if (tif.bit_tick === 1'b1) ticks++;
      if (tif.frame_done === 1'b1) begin
        done = 1;
        chk({tag, "_done_cycle"}, cyc, exp_q.pop_front());
      end
    end
    if (!done) begin
      chk({tag, "_done_seen"}, 0, 1);
      void'(exp_q.pop_front());
    end
    chk({tag, "_trace_first_bad_", first}, mism, 0);
    chk({tag, "_bit_ticks"}, ticks, fl);
  endtask

  task automatic done_hold(input string tag);
    int bad;
    bad = 0;
    repeat (3) begin
      step();
      if (tif.busy !== 1'b0 || tif.edge_cnt !== '0 || tif.bit_cnt !== '0 ||
          tif.frame_done !== 1'b0 || tif.bit_tick !== 1'b0 || tif.sample_en !== 1'b0)
        bad++;
    end
    chk({tag, "_done_hold"}, bad, 0);
  endtask

  task automatic go_idle(input string tag);
    tif.enable = 1'b0;
    step();
    chk({tag, "_idle_busy"}, tif.busy, 0);
  endtask

  initial begin
    tif.prescale = 8;
    tif.par_en   = 1'b0;
    tif.stop2    = 1'b0;
    tif.enable   = 1'b0;
    tif.restart  = 1'b0;

    #3;
    chk("rst_busy",       tif.busy, 0);
    chk("rst_edge_cnt",   tif.edge_cnt, 0);
    chk("rst_bit_cnt",    tif.bit_cnt, 0);
    chk("rst_sample_en",  tif.sample_en, 0);
    chk("rst_bit_tick",   tif.bit_tick, 0);
    chk("rst_frame_done", tif.frame_done, 0);
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("idle_no_enable_busy", tif.busy, 0);

    // 8x oversampling, 8N1
    tif.enable = 1'b1;
    run_frame("p8_8n1", 8, 10, 0);
    done_hold("p8_8n1");
    go_idle("p8_8n1");

    // 16x, parity, two stops
    tif.prescale = 16; tif.par_en = 1'b1; tif.stop2 = 1'b1;
    tif.enable = 1'b1;
    run_frame("p16_8e2", 16, 12, 0);
    done_hold("p16_8e2");
    go_idle("p16_8e2");

    // prescale below floor clamps to 4
    tif.prescale = 2; tif.par_en = 1'b0; tif.stop2 = 1'b0;
    tif.enable = 1'b1;
    run_frame("p2_clamp", 4, 10, 0);
    done_hold("p2_clamp");
    go_idle("p2_clamp");

    // config change at bit 3 is ignored until the next frame
    tif.prescale = 8;
    tif.enable = 1'b1;
    run_frame("cfg_frozen", 8, 10, 25);
    done_hold("cfg_frozen");
    go_idle("cfg_frozen");
    tif.enable = 1'b1;
    run_frame("cfg_next", 16, 11, 0);
    done_hold("cfg_next");
    go_idle("cfg_next");
    tif.prescale = 8; tif.par_en = 1'b0;

    // abort at bit 5 edge 3
    tif.enable = 1'b1;
    repeat (44) step();
    chk("abort_pre_edge", tif.edge_cnt, 3);
    chk("abort_pre_bit",  tif.bit_cnt, 5);
    tif.enable = 1'b0;
    step();
    chk("abort_busy",       tif.busy, 0);
    chk("abort_edge_cnt",   tif.edge_cnt, 0);
    chk("abort_bit_cnt",    tif.bit_cnt, 0);
    chk("abort_frame_done", tif.frame_done, 0);

    // restart at bit 4 restarts a full frame
    tif.enable = 1'b1;
    repeat (33) step();
    chk("restart_pre_bit",  tif.bit_cnt, 4);
    chk("restart_pre_edge", tif.edge_cnt, 0);
    tif.restart = 1'b1;
    run_frame("restart", 8, 10, 0);
    done_hold("restart");
    go_idle("restart");

    // async reset mid-frame at bit 6 edge 4 (inside the sample window)
    tif.enable = 1'b1;
    repeat (53) step();
    chk("arst_pre_bit",    tif.bit_cnt, 6);
    chk("arst_pre_sample", tif.sample_en, 1);
    #1 RST = 1'b0;
    #1;
    chk("arst_busy",      tif.busy, 0);
    chk("arst_edge_cnt",  tif.edge_cnt, 0);
    chk("arst_bit_cnt",   tif.bit_cnt, 0);
    chk("arst_sample_en", tif.sample_en, 0);
    #1 RST = 1'b1;
    run_frame("after_arst", 8, 10, 0);
    done_hold("after_arst");
    go_idle("after_arst");

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
